// File: rtl/lifting_polyphase_splitter.sv
// Lifting-stage feeder: splits a serial sample stream x[k] into overlapping
// polyphase triples (x[2n], x[2n+1], x[2n+2]) with end-of-record padding
// and a ready/valid handshake on both sides.
module lifting_polyphase_splitter #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] y2n,
    output logic [DW-1:0] y2n_1,
    output logic [DW-1:0] y2na,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [CW-1:0] pair_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_EVEN  = 2'd1,
        S_ODD   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   flush_pend;
    logic   flush_pend_nxt;

    logic in_xfer;
    logic out_xfer;
    logic flush_req;

    // Datapath load/modify strobes decoded from the FSM
    logic ld_even_in;
    logic ld_odd_in;
    logic ld_la_in;
    logic pad_even;
    logic pad_odd;
    logic adv;
    logic set_out;
    logic set_last;
    logic clr_out;
    logic cnt_inc;
    logic cnt_clr;

    // in_ready depends only on registered state, so out_ready never reaches it
    assign in_ready  = (state != S_OUT);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign flush_req = flush || flush_pend;
    assign busy      = (state != S_EMPTY) || flush_pend;

    // State and pending-flush registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Next-state and strobe decode; an accepted sample always wins over
    // padding, and a coincident flush is carried forward in flush_pend
    always_comb begin
        state_nxt      = state;
        flush_pend_nxt = flush_pend;
        ld_even_in     = 1'b0;
        ld_odd_in      = 1'b0;
        ld_la_in       = 1'b0;
        pad_even       = 1'b0;
        pad_odd        = 1'b0;
        adv            = 1'b0;
        set_out        = 1'b0;
        set_last       = 1'b0;
        clr_out        = 1'b0;
        cnt_inc        = 1'b0;
        cnt_clr        = 1'b0;
        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    ld_even_in     = 1'b1;
                    flush_pend_nxt = flush_pend || flush;
                    state_nxt      = S_EVEN;
                end else begin
                    flush_pend_nxt = 1'b0;
                    if (flush) begin
                        cnt_clr = 1'b1;
                    end
                end
            end
            S_EVEN: begin
                if (in_xfer) begin
                    ld_odd_in      = 1'b1;
                    flush_pend_nxt = flush_pend || flush;
                    state_nxt      = S_ODD;
                end else if (flush_req) begin
                    pad_even       = 1'b1;
                    set_out        = 1'b1;
                    set_last       = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = S_OUT;
                end
            end
            S_ODD: begin
                if (in_xfer) begin
                    ld_la_in       = 1'b1;
                    set_out        = 1'b1;
                    flush_pend_nxt = flush_pend || flush;
                    state_nxt      = S_OUT;
                end else if (flush_req) begin
                    pad_odd        = 1'b1;
                    set_out        = 1'b1;
                    set_last       = 1'b1;
                    flush_pend_nxt = 1'b0;
                    state_nxt      = S_OUT;
                end
            end
            S_OUT: begin
                if (flush && !out_last) begin
                    flush_pend_nxt = 1'b1;
                end
                if (out_xfer) begin
                    clr_out = 1'b1;
                    cnt_inc = 1'b1;
                    if (out_last) begin
                        cnt_clr        = 1'b1;
                        flush_pend_nxt = 1'b0;
                        state_nxt      = S_EMPTY;
                    end else begin
                        adv       = 1'b1;
                        state_nxt = S_EVEN;
                    end
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // Sample registers and output flags; look-ahead even rolls into the even slot
    always_ff @(posedge clk) begin
        if (rst) begin
            y2n       <= '0;
            y2n_1     <= '0;
            y2na      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (ld_even_in) begin
                y2n <= in_data;
            end else if (adv) begin
                y2n <= y2na;
            end

            if (ld_odd_in) begin
                y2n_1 <= in_data;
            end else if (pad_even) begin
                y2n_1 <= y2n;
            end

            if (ld_la_in) begin
                y2na <= in_data;
            end else if (pad_even) begin
                y2na <= y2n;
            end else if (pad_odd) begin
                y2na <= y2n_1;
            end

            if (set_out) begin
                out_valid <= 1'b1;
                out_last  <= set_last;
            end else if (clr_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Count of consumed triples; cleared at record end, wraps otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count <= '0;
        end else if (cnt_clr) begin
            pair_count <= '0;
        end else if (cnt_inc) begin
            pair_count <= pair_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_lifting_polyphase_splitter.sv
// Self-checking bench for lifting_polyphase_splitter: expected triples are
// queued as samples are driven and checked as the DUT hands them off.
module tb_lifting_polyphase_splitter;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] y2n;
    logic [DW-1:0] y2n_1;
    logic [DW-1:0] y2na;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] pair_count;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] e;
        logic [DW-1:0] o;
        logic [DW-1:0] a;
        logic          last;
    } trip_t;

    trip_t q[$];
    int    tests;
    int    fails;

    lifting_polyphase_splitter #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .y2n       (y2n),
        .y2n_1     (y2n_1),
        .y2na      (y2na),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pair_count(pair_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each handed-off triple must match the oldest queued one;
    // in_ready must be low exactly while a triple is presented
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (in_ready !== !out_valid) begin
                fails++;
                $display("FAIL in_ready_vs_state: in_ready=%b out_valid=%b, want in_ready=%b",
                         in_ready, out_valid, !out_valid);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_triple: got (%0d,%0d,%0d,last=%b), none expected",
                             $signed(y2n), $signed(y2n_1), $signed(y2na), out_last);
                end else begin
                    trip_t exp_t;
                    exp_t = q.pop_front();
                    if (y2n !== exp_t.e || y2n_1 !== exp_t.o || y2na !== exp_t.a ||
                        out_last !== exp_t.last) begin
                        fails++;
                        $display("FAIL triple: got (%h,%h,%h,last=%b) want (%h,%h,%h,last=%b)",
                                 y2n, y2n_1, y2na, out_last, exp_t.e, exp_t.o, exp_t.a, exp_t.last);
                    end
                end
            end
        end
    end

    function automatic trip_t mk(input int e, input int o, input int a, input logic last);
        trip_t t;
        t.e    = DW'(e);
        t.o    = DW'(o);
        t.a    = DW'(a);
        t.last = last;
        return t;
    endfunction

    task automatic apply_reset();
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        rst      = 1'b1;
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Offer one sample and hold it until the DUT accepts it
    task automatic send(input int v);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(v);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: sample %0d not accepted, want accepted within 100 cycles", v);
        end
    endtask

    // Wait until at most n triples remain outstanding
    task automatic wait_q(input int n);
        for (int i = 0; i < 200; i++) begin
            if (q.size() <= n) break;
            @(posedge clk); #1;
        end
        if (q.size() > n) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d triples outstanding, want %0d", q.size(), n);
            q.delete();
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        tests++;
        if (y2n !== '0 || y2n_1 !== '0 || y2na !== '0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || pair_count !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: y=(%h,%h,%h) ov=%b ol=%b pc=%0d busy=%b ir=%b, want zeros, ir=1",
                     y2n, y2n_1, y2na, out_valid, out_last, pair_count, busy, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        q.push_back(mk(1, 2, 3, 1'b0));
        q.push_back(mk(3, 4, 5, 1'b0));
        for (int v = 1; v <= 5; v++) send(v);
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== CW'(2) || busy !== 1'b1) begin
            fails++;
            $display("FAIL stream_count: pc=%0d busy=%b, want pc=2 busy=1", pair_count, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        q.push_back(mk(10, 20, 30, 1'b0));
        send(10);
        send(20);
        send(30);
        in_valid = 1'b1;
        in_data  = DW'(40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (y2n !== DW'(10) || y2n_1 !== DW'(20) || y2na !== DW'(30) ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: cyc %0d y=(%0d,%0d,%0d) ov=%b ir=%b, want (10,20,30) ov=1 ir=0",
                         i, y2n, y2n_1, y2na, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        q.push_back(mk(30, 40, 50, 1'b0));
        out_ready = 1'b1;
        send(40);
        send(50);
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== CW'(2)) begin
            fails++;
            $display("FAIL stall_count: pc=%0d, want 2", pair_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_even();
        apply_reset();
        out_ready = 1'b1;
        q.push_back(mk(7, 8, 9, 1'b0));
        q.push_back(mk(9, 10, 11, 1'b0));
        q.push_back(mk(11, 11, 11, 1'b1));
        for (int v = 7; v <= 11; v++) send(v);
        wait_q(1);
        pulse_flush();
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_even_end: pc=%0d busy=%b, want pc=0 busy=0", pair_count, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_odd();
        apply_reset();
        out_ready = 1'b1;
        q.push_back(mk(-4, 6, 6, 1'b1));
        send(-4);
        send(6);
        pulse_flush();
        @(negedge clk);
        tests++;
        if (y2n !== 32'hFFFF_FFFC || out_valid !== 1'b1 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL flush_odd_sign: y2n=%h ov=%b ol=%b, want FFFFFFFC ov=1 ol=1",
                     y2n, out_valid, out_last);
        end
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_odd_end: pc=%0d busy=%b, want pc=0 busy=0", pair_count, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_in_out();
        apply_reset();
        out_ready = 1'b0;
        q.push_back(mk(1, 2, 3, 1'b0));
        q.push_back(mk(3, 3, 3, 1'b1));
        send(1);
        send(2);
        send(3);
        pulse_flush();
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL flush_pend_hold: busy=%b ov=%b ol=%b, want 1,1,0", busy, out_valid, out_last);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_out_end: pc=%0d busy=%b, want pc=0 busy=0", pair_count, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_with_input();
        apply_reset();
        out_ready = 1'b1;
        q.push_back(mk(20, 20, 20, 1'b1));
        flush = 1'b1;
        send(20);
        flush = 1'b0;
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_input_end: pc=%0d busy=%b, want pc=0 busy=0", pair_count, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        send(1);
        send(2);
        send(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || y2n !== '0 || y2n_1 !== '0 || y2na !== '0 ||
            pair_count !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: ov=%b y=(%h,%h,%h) pc=%0d busy=%b, want all zero",
                     out_valid, y2n, y2n_1, y2na, pair_count, busy);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        q.push_back(mk(5, 6, 7, 1'b0));
        send(5);
        send(6);
        send(7);
        wait_q(0);
        @(negedge clk);
        tests++;
        if (pair_count !== CW'(1)) begin
            fails++;
            $display("FAIL reset_mid_count: pc=%0d, want 1", pair_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush_even();
        test_flush_odd();
        test_flush_in_out();
        test_flush_with_input();
        test_reset_mid();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover_triples: %0d outstanding, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lifting_polyphase_splitter.md
Name: lifting_polyphase_splitter

Overview:
- Upstream feeder of the lifting stage.
- Converts the serial ECG sample stream x[k] into overlapping polyphase triples: even x[2n], odd x[2n+1] and look-ahead even x[2n+2].
- These triples drive the lifting stage's y2n, y2n_1 and y2na inputs.
- Handles end-of-record padding and output back-pressure.

Parameters:
DW, 32, sample width in bits (two's complement, passed through unmodified)
CW, 16, width of the pair counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_data  in  DW  incoming ECG sample x[k]
in_valid  in  1  in_data valid this cycle
in_ready  out  1  block accepts in_data this cycle
flush  in  1  end-of-record request, single-cycle pulse
y2n  out  DW  even sample x[2n]
y2n_1  out  DW  odd sample x[2n+1]
y2na  out  DW  look-ahead even sample x[2n+2]
out_valid  out  1  triple on y2n/y2n_1/y2na valid
out_ready  in  1  lifting stage consumes triple
out_last  out  1  triple is the final one of the record (padded)
pair_count  out  CW  triples consumed since reset/flush completion
busy  out  1  high whenever state is not S_EMPTY

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-handshake):
  - state=S_EMPTY.
  - y2n, y2n_1, y2na, pair_count = 0; out_valid, out_last = 0.
  - Pending flush discarded.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = (state != S_OUT); registered-state decode only, no combinational path from out_ready.
- S_EMPTY (no samples held): input transfer -> y2n<=in_data, go S_EVEN.
- S_EVEN (even held): input transfer -> y2n_1<=in_data, go S_ODD.
- S_ODD (even+odd held): input transfer -> y2na<=in_data, out_valid<=1, out_last<=0, go S_OUT.
  - Latency: out_valid rises 1 cycle after the third sample's transfer.
- S_OUT (triple presented):
  - Outputs held stable while out_ready=0.
  - On output transfer: pair_count+=1 (wraps mod 2^CW), out_valid<=0.
  - If out_last=1: pair_count<=0, go S_EMPTY.
  - Otherwise: y2n<=y2na (look-ahead even becomes next even), go S_EVEN.
  - Resulting overlap: consecutive triples are (x0,x1,x2), (x2,x3,x4), ...
- Flush, end-of-record padding by repeating the last received sample:
  - S_EMPTY: no effect; pair_count<=0.
  - S_EVEN: y2n_1<=y2n, y2na<=y2n, out_valid<=1, out_last<=1, go S_OUT.
  - S_ODD: y2na<=y2n_1, out_valid<=1, out_last<=1, go S_OUT.
  - S_OUT with out_last=0: latch flush_pend. After this triple transfers, the block is in S_EVEN holding x[2n+2] and emits a padded triple (x,x,x) with out_last=1 in the next cycle, without waiting for input.
  - S_OUT with out_last=1: ignored.
- Simultaneous flush and input transfer in the same cycle:
  - Sample accepted first.
  - Padding applies to the resulting state on the next cycle, via flush_pend.
- Arithmetic: none on data, pure registers. No sign manipulation. Widths are exact DW.
- busy = (state != S_EMPTY) || flush_pend.
- Throughput: at most one input per cycle. One triple every 2 input samples in steady state, plus 1 bubble cycle per triple in S_OUT.

Test Plan:
- Reset, then stream 1,2,3,4,5 with out_ready=1:
  - Triples (1,2,3), then (3,4,5), both out_last=0.
  - pair_count=2.
  - in_ready low exactly during S_OUT cycles.
- Back-pressure: present triple (10,20,30) with out_ready=0 for 5 cycles.
  - Outputs and out_valid stable throughout; in_ready=0; no input lost.
  - Release -> next triple begins with y2n=30.
- Flush in S_EVEN after samples 7,8,9,10,11 (state holds 11):
  - Padded triple (11,11,11) with out_last=1.
  - After transfer: pair_count=0, busy=0.
- Flush in S_ODD holding (-4,6):
  - Triple (-4,6,6) with out_last=1.
  - Sign bits preserved, e.g. 0xFFFFFFFC.
- Flush asserted while S_OUT holds (1,2,3), out_ready=0:
  - After transfer, triple (3,3,3) with out_last=1.
- rst mid-stream while out_valid=1:
  - Next cycle out_valid=0 and all outputs 0.
  - Stream 5,6,7 -> (5,6,7), pair_count=1.
